// File: rtl/ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_unit
// Description : Multi-cycle restoring radix-2 integer divider for the EX
//               stage. Requests a pipeline stall while a divide is in flight
//               and holds its result until the EX stage advances.
//               Optional macro DIV_EARLY_OUT_EN: skip iteration when the
//               divisor magnitude exceeds the dividend magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div_unit #(
  parameter int DATA_W       = 32,
  parameter int STALL_W      = 6,
  parameter int EX_STALL_BIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [DATA_W-1:0]  dividend,
  input  logic [DATA_W-1:0]  divisor,
  output logic               stallreq_ex,
  output logic               result_valid,
  output logic [DATA_W-1:0]  quotient,
  output logic [DATA_W-1:0]  remainder,
  output logic               div_by_zero
);

  localparam int                CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_prem;   // restored partial remainder (always < divisor)
  logic [DATA_W-1:0]  r_dvd;    // dividend bits shift out MSB-first, quotient bits shift in
  logic [DATA_W-1:0]  r_dvs;
  logic               r_qsign;
  logic               r_rsign;
  logic [DATA_W-1:0]  r_quo;
  logic [DATA_W-1:0]  r_rem;
  logic               r_dbz;

  logic               w_start;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [DATA_W-1:0]  w_dvd_mag;
  logic [DATA_W-1:0]  w_dvs_mag;
  logic               w_dvs_zero;
  logic               w_early;
  logic [DATA_W:0]    w_shift;
  logic [DATA_W+1:0]  w_diff;
  logic               w_qbit;
  logic [DATA_W-1:0]  w_prem_nx;
  logic [DATA_W-1:0]  w_quo_nx;
  logic               w_last;
  logic               w_unused_bits;

  assign w_start    = div_start & ~flush;
  assign w_dvd_neg  = div_signed & dividend[DATA_W-1];
  assign w_dvs_neg  = div_signed & divisor[DATA_W-1];
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
  assign w_dvs_zero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = ~w_dvs_zero & (w_dvs_mag > w_dvd_mag);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: the shifted partial remainder needs DATA_W+1 bits,
  // and one more bit on the difference gives an unambiguous borrow.
  assign w_shift   = {r_prem, r_dvd[DATA_W-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_qbit    = ~w_diff[DATA_W+1];
  assign w_prem_nx = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_quo_nx  = {r_dvd[DATA_W-2:0], w_qbit};
  assign w_last    = (r_cnt == C_LAST);

  // Top difference bit below the borrow is provably zero after a successful subtract.
  assign w_unused_bits = ^{stall, w_diff[DATA_W]};

  assign result_valid = (r_state == S_DONE);
  assign quotient     = r_quo;
  assign remainder    = r_rem;
  assign div_by_zero  = r_dbz;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and the combinational stall request.
  always_comb begin
    w_next      = r_state;
    stallreq_ex = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          stallreq_ex = 1'b1;
          w_next      = (w_dvs_zero | w_early) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stallreq_ex = ~flush;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (!stall[EX_STALL_BIT]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
    if (rst)   stallreq_ex = 1'b0;
  end

  // Operand capture, iteration, sign fix-up and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_prem  <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt   <= '0;
            r_prem  <= '0;
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_qsign <= w_dvd_neg ^ w_dvs_neg;
            r_rsign <= w_dvd_neg;
            if (w_dvs_zero) begin
              r_quo <= '1;
              r_rem <= dividend;
              r_dbz <= 1'b1;
            end else if (w_early) begin
              r_quo <= '0;
              r_rem <= dividend;
              r_dbz <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + 1'b1;
          r_prem <= w_prem_nx;
          r_dvd  <= w_quo_nx;
          if (w_last && !flush) begin
            r_quo <= r_qsign ? -w_quo_nx : w_quo_nx;
            r_rem <= r_rsign ? -w_prem_nx : w_prem_nx;
            r_dbz <= 1'b0;
          end
        end
        S_DONE: begin
          if (w_next == S_IDLE) r_dbz <= 1'b0;
        end
        default: r_dbz <= 1'b0;
      endcase
      if (flush) r_dbz <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ex_div_unit
// Description : Self-checking bench for ex_div_unit. Vector table plus
//               hand-written flush / hold sequences; results are matched
//               through an expected-result queue. Honours DIV_EARLY_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stallreq_ex;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  ex_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .stallreq_ex  (stallreq_ex),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`endif
    if (ma == mb + 32'd1) return 33;  // keeps both magnitudes referenced in every build
    return 33;
  endfunction

  // Runs one divide: start in cycle 0, operands scrambled after acceptance,
  // counts stall-request cycles, then optionally holds DONE via the stall vector.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input int hold);
    exp_t e;
    int   cyc;
    int   sreq;
    bit   got;
    int   elat;
    elat = exp_lat(sg, a, b);
    e.q = eq; e.r = er; e.dbz = edbz;
    sb.push_back(e);
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = sg; dividend = a; divisor = b;
    cyc = 0; sreq = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (stallreq_ex) sreq++;
      if (result_valid) got = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
        dividend = ~a; divisor = ~b;
      end
    end
    check("stallreq_cycles", sreq, elat);
    check("done_cycle", cyc, elat);
    e = sb.pop_front();
    if (got) begin
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      stall = (hold > 0) ? 6'h3F : 6'h00;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, result_valid}, 32'd1);
        check("hold_stallreq", {31'd0, stallreq_ex}, 32'd0);
        check("hold_quotient", quotient, e.q);
        check("hold_remainder", remainder, e.r);
      end
      stall = 6'h00; div_start = 1'b0;
      @(negedge clk);
      check("exit_valid", {31'd0, result_valid}, 32'd0);
      check("exit_stallreq", {31'd0, stallreq_ex}, 32'd0);
    end else begin
      div_start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 0};
    vecs[2]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 4};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 0};
    vecs[4]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 0};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 4};
    vecs[6]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 0};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 0};
    vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 0};
    vecs[10] = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b0, 0};
    vecs[11] = '{1'b0, 32'hDEADBEEF,   32'h00001234,   32'h000C3BA5,   32'h0000076B,   1'b0, 0};

    rst = 1'b1; stall = 6'h00; flush = 1'b0;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stallreq", {31'd0, stallreq_ex}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; div_start = 1'b0;

    for (int i = 0; i < 12; i++)
      do_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].hold);

    // Random unsigned divides against a behavioural model.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom_range(1, 70000);
      do_div(1'b0, ra, rb, ra / rb, ra % rb, 1'b0, 0);
    end

    // Flush in CALC cycle 10: request drops at once, no result ever appears.
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stallreq", {31'd0, stallreq_ex}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (result_valid || stallreq_ex) seen++;
      end
      check("flush_no_result", seen, 32'd0);
    end
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    // Flush while held in DONE clears result_valid and div_by_zero next cycle.
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd5; divisor = 32'd0;
    @(posedge clk); #1;
    stall = 6'h3F;
    @(negedge clk);
    check("done_valid", {31'd0, result_valid}, 32'd1);
    check("done_dbz", {31'd0, div_by_zero}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("done_flush_stallreq", {31'd0, stallreq_ex}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0; stall = 6'h00;
    @(negedge clk);
    check("flushed_valid", {31'd0, result_valid}, 32'd0);
    check("flushed_dbz", {31'd0, div_by_zero}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Multi-cycle iterative integer divider in the EX stage. It is the requester side of the pipeline stall handshake: it raises stallreq_ex to the stall controller while a divide is in flight. It then watches the returned stall vector and holds its result until the EX stage actually advances. It produces quotient and remainder for signed and unsigned divide instructions.

Parameters:
DATA_W, 32, operand and result width
STALL_W, 6, stall vector width (bit 0 = pc ... bit 5 = wb)
EX_STALL_BIT, 3, index of the EX-stage bit in stall

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  STALL_W  stall vector from the stall controller
flush  input  1  cancel any in-flight divide (exception/redirect)
div_start  input  1  EX holds a divide instruction; held high while that instruction sits in EX
div_signed  input  1  1 = signed divide, 0 = unsigned; sampled with div_start
dividend  input  DATA_W  sampled on the accepted start cycle
divisor  input  DATA_W  sampled on the accepted start cycle
stallreq_ex  output  1  stall request to the stall controller
result_valid  output  1  quotient/remainder valid
quotient  output  DATA_W  result quotient
remainder  output  DATA_W  result remainder
div_by_zero  output  1  last result came from a zero divisor; valid with result_valid

Behaviour:
- Reset (rst=1 at a clock edge): state goes to IDLE; counter is cleared; quotient, remainder, result_valid and div_by_zero are all 0. stallreq_ex is 0 while rst=1. Reset mid-operation aborts the divide.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - A start is accepted when div_start=1 and flush=0.
  - On acceptance, latch magnitudes. In signed mode use the absolute value of each operand; in unsigned mode use the raw value. Also latch the quotient sign (sign of dividend XOR sign of divisor) and the remainder sign (sign of dividend).
  - If divisor==0, go to DONE with quotient=all ones, remainder=dividend (unmodified) and div_by_zero=1.
  - Otherwise go to CALC with counter=0.
- CALC:
  - Restoring radix-2 division, one quotient bit per cycle, MSB first.
  - Partial remainder is DATA_W+1 bits wide. Each cycle: shift in the next dividend bit, subtract the divisor magnitude, and restore if the result is negative.
  - After DATA_W iterations (counter reaches DATA_W-1), go to DONE.
  - On entry to DONE, apply signs: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Iteration continues regardless of stall.
- DONE:
  - result_valid=1.
  - Stay in DONE while stall[EX_STALL_BIT]=1; outputs are held stable.
  - Go to IDLE when stall[EX_STALL_BIT]=0, because the instruction leaves EX that cycle.
  - div_start is ignored in DONE, so the same instruction is never restarted.
- stallreq_ex is combinational: (IDLE & div_start & ~flush) | (CALC & ~flush). It is 0 in DONE.
- Latency, nonzero divisor:
  - Start accepted in cycle 0; CALC occupies cycles 1..DATA_W; DONE from cycle DATA_W+1.
  - stallreq_ex is high in cycles 0..DATA_W, i.e. DATA_W+1 cycles.
- Latency, zero divisor: stallreq_ex is high for 1 cycle; DONE from cycle 1.
- flush=1 in any state:
  - stallreq_ex drops the same cycle.
  - Next state is IDLE.
  - result_valid and div_by_zero clear on the next cycle.
  - A start is not accepted in that cycle.
- result_valid drops in the cycle after leaving DONE.
- Signed overflow: -2^(DATA_W-1) / -1 gives quotient 0x80000000 and remainder 0, with no special case.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, if the divisor is nonzero and the divisor magnitude is greater than the dividend magnitude, skip CALC. Go directly to DONE with quotient=0 and remainder=dividend (original signed value); stallreq_ex is high for 1 cycle.
- Undefined: all nonzero divides take the full DATA_W-cycle CALC path.

Test Plan:
- Unsigned 100/7, stall=0 after DONE: stallreq_ex high exactly 33 cycles; result_valid in cycle 33 with quotient=14, remainder=2; IDLE in cycle 34.
- Signed -7/2 (0xFFFFFFF9 / 2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, div_by_zero=0.
- 5/0 unsigned: stallreq_ex high 1 cycle; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Hold in DONE: drive stall=6'b111111 for 4 cycles after DONE. Outputs stay stable, result_valid=1, stallreq_ex=0, div_start is not restarted. Release stall, then IDLE next cycle.
- Flush at CALC cycle 10: stallreq_ex=0 the same cycle; IDLE next cycle; result_valid never asserts. A new 9/3 then returns quotient=3, remainder=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. With DIV_EARLY_OUT_EN defined, 3/10 gives quotient=0 and remainder=3 after a 1-cycle stall.
